// File: rtl/clkdiv_sync_ctrl.sv
// clkdiv_sync_ctrl: timed reset/RELEASE sequencer for a CLKDIVB-style clock divider
// Ports:
//   CLKI        - controller clock, same net as the divider input clock
//   RST         - synchronous active-high reset
//   LOCK        - PLL lock, already synchronous to CLKI
//   RESYNC_REQ  - resync request level, held until RESYNC_ACK
//   RESYNC_ACK  - one-cycle pulse on the first RUN cycle of a requested resync
//   DIV_RST     - divider reset input
//   DIV_RELEASE - divider RELEASE input
//   READY       - divided clocks running and aligned
// Optional (CLKDIV_SYNC_CTRL_STATUS_EN defined):
//   RESYNC_CNT  - saturating count of RUN entries after the first one since reset
//   LOCK_LOST   - sticky flag, LOCK dropped outside IDLE since reset
module clkdiv_sync_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int REL_DELAY  = 8,
    parameter int CNT_W      = 8
) (
    input  logic       CLKI,
    input  logic       RST,
    input  logic       LOCK,
    input  logic       RESYNC_REQ,
    output logic       RESYNC_ACK,
    output logic       DIV_RST,
    output logic       DIV_RELEASE,
    output logic       READY
`ifdef CLKDIV_SYNC_CTRL_STATUS_EN
    ,
    output logic [7:0] RESYNC_CNT,
    output logic [0:0] LOCK_LOST
`endif
);
    if (RST_CYCLES < 1 || RST_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_rst
        $error("clkdiv_sync_ctrl: RST_CYCLES out of range");
    end
    if (REL_DELAY < 1 || REL_DELAY > (2 ** CNT_W) - 1) begin : g_bad_rel
        $error("clkdiv_sync_ctrl: REL_DELAY out of range");
    end
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LOAD = CNT_W'(REL_DELAY - 1);
    typedef enum logic [1:0] {IDLE, HOLD, ARM, RUN} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             pending_q, pending_d, ack_d;
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pending_d = pending_q;
        ack_d     = 1'b0;
        // lock loss wins over timer expiry and resync requests; pending survives it
        if (state_q != IDLE && !LOCK) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                HOLD: begin
                    state_d = timer_q == '0 ? ARM : HOLD;
                    timer_d = timer_q == '0 ? REL_LOAD : timer_q - 1'b1;
                end
                ARM: begin
                    if (timer_q == '0) begin
                        state_d   = RUN;
                        ack_d     = pending_q;
                        pending_d = 1'b0;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                RUN: begin
                    // the ACK cycle ignores REQ so the requester has time to drop it
                    if (RESYNC_REQ && !RESYNC_ACK) begin
                        state_d   = HOLD;
                        timer_d   = RST_LOAD;
                        pending_d = 1'b1;
                    end
                end
                default: begin
                    if (LOCK) begin
                        state_d = HOLD;
                        timer_d = RST_LOAD;
                    end
                end
            endcase
        end
    end
    // outputs are registered from the next state so they match the state register exactly
    always_ff @(posedge CLKI) begin
        if (RST) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            pending_q   <= 1'b0;
            RESYNC_ACK  <= 1'b0;
            DIV_RST     <= 1'b1;
            DIV_RELEASE <= 1'b0;
            READY       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pending_q   <= pending_d;
            RESYNC_ACK  <= ack_d;
            DIV_RST     <= state_d == IDLE || state_d == HOLD;
            DIV_RELEASE <= state_d == RUN;
            READY       <= state_d == RUN;
        end
    end
`ifdef CLKDIV_SYNC_CTRL_STATUS_EN
    logic first_q;
    always_ff @(posedge CLKI) begin
        if (RST) begin
            RESYNC_CNT <= '0;
            LOCK_LOST  <= '0;
            first_q    <= 1'b0;
        end else begin
            if (state_q != IDLE && !LOCK) LOCK_LOST <= 1'b1;
            // the first RUN entry after reset is the power-up, not a resync
            if (state_d == RUN && state_q != RUN) begin
                first_q <= 1'b1;
                if (first_q && RESYNC_CNT != 8'hFF) RESYNC_CNT <= RESYNC_CNT + 8'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_clkdiv_sync_ctrl.sv
// tb_clkdiv_sync_ctrl: randomized self-checking bench against a cycle-age reference model
module tb_clkdiv_sync_ctrl;
    localparam int R = 4;
    localparam int D = 8;
    logic clk = 1'b0, rst = 1'b1, lock = 1'b0, req = 1'b0;
    logic ack, drst, drel, ready;
`ifdef CLKDIV_SYNC_CTRL_STATUS_EN
    logic [7:0] rcnt;
    logic [0:0] lost;
`endif
    int n_tests = 0, n_fail = 0;
    bit m_active = 0, m_pend = 0, m_ack = 0, m_first = 0, m_lost = 0;
    int m_age = 0, m_cnt = 0;

    always #5 clk = ~clk;

    clkdiv_sync_ctrl #(.RST_CYCLES(R), .REL_DELAY(D), .CNT_W(8)) dut (
        .CLKI(clk), .RST(rst), .LOCK(lock), .RESYNC_REQ(req),
        .RESYNC_ACK(ack), .DIV_RST(drst), .DIV_RELEASE(drel), .READY(ready)
`ifdef CLKDIV_SYNC_CTRL_STATUS_EN
        , .RESYNC_CNT(rcnt), .LOCK_LOST(lost)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // model: a sequence is "active" once LOCK is seen; its age in cycles alone decides the phase
    task automatic model_step();
        bit in_run, old_ack;
        in_run  = m_active && m_age >= R + D;
        old_ack = m_ack;
        if (rst) begin
            m_active = 0; m_pend = 0; m_ack = 0; m_first = 0; m_lost = 0; m_cnt = 0; m_age = 0;
        end else begin
            m_ack = 0;
            if (m_active && !lock) begin
                m_active = 0;
                m_lost   = 1;
            end else if (!m_active) begin
                if (lock) begin
                    m_active = 1;
                    m_age    = 0;
                end
            end else if (in_run) begin
                if (req && !old_ack) begin
                    m_age  = 0;
                    m_pend = 1;
                end
            end else begin
                m_age++;
                if (m_age == R + D) begin
                    m_ack  = m_pend;
                    m_pend = 0;
                    if (m_first && m_cnt < 255) m_cnt++;
                    m_first = 1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        bit e_run;
        e_run = m_active && m_age >= R + D;
        chk("div_rst", drst, !m_active || m_age < R);
        chk("div_release", drel, e_run);
        chk("ready", ready, e_run);
        chk("resync_ack", ack, m_ack);
        chk("rst_release_excl", {drst, drel} == 2'b11, 0);
`ifdef CLKDIV_SYNC_CTRL_STATUS_EN
        chk("resync_cnt", rcnt, m_cnt);
        chk("lock_lost", lost, m_lost);
`endif
    endtask

    task automatic cycle(input logic r, input logic l, input logic q);
        rst = r; lock = l; req = q;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_resync(input string tag);
        int n = 0;
        do begin cycle(0, 1, 1); n++; end while (!ack && n < 40);
        chk(tag, n, R + D + 1);
        cycle(0, 1, 0);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        do begin cycle(0, 1, 0); n++; end while (!ready && n < 40);
        chk(tag, ready, 1);
    endtask

    initial begin
        int n;
        bit seen;
        logic r, l, q;
        repeat (3) cycle(1, 0, 0);
        chk("reset_div_rst", drst, 1);
        chk("reset_ready", ready, 0);
        n = 0;
        do begin cycle(0, 1, 0); n++; end while (!ready && n < 40);
        chk("powerup_latency", n, R + D + 1);
        repeat (5) cycle(0, 1, 0);
        do_resync("resync_latency");
        repeat (20) cycle(0, 1, 0);
        chk("no_second_resync", ready, 1);
        // request accepted, then lock lost on the 3rd ARM cycle with the resync pending
        cycle(0, 1, 1);
        repeat (R + 2) cycle(0, 1, 0);
        chk("arm_phase", {drst, drel}, 2'b00);
        cycle(0, 0, 0);
        chk("lockloss_idle", drst, 1);
        repeat (2) cycle(0, 0, 0);
        n = 0;
        do begin cycle(0, 1, 0); n++; end while (!ack && n < 40);
        chk("pending_ack_after_relock", n, R + D + 1);
        repeat (3) cycle(0, 1, 0);
        // reset during HOLD with a pending resync: no ACK afterwards
        cycle(0, 1, 1);
        cycle(0, 1, 0);
        cycle(1, 1, 0);
        chk("midrst_div_rst", drst, 1);
        chk("midrst_ready", ready, 0);
`ifdef CLKDIV_SYNC_CTRL_STATUS_EN
        chk("midrst_cnt", rcnt, 0);
        chk("midrst_lost", lost, 0);
`endif
        seen = 0;
        repeat (30) begin cycle(0, 1, 0); seen |= ack; end
        chk("no_ack_after_rst", seen, 0);
        repeat (3) do_resync("status_resync");
`ifdef CLKDIV_SYNC_CTRL_STATUS_EN
        chk("cnt_after_3", rcnt, 3);
`endif
        cycle(0, 0, 0);
        cycle(0, 1, 0);
        wait_ready("relock_ready");
`ifdef CLKDIV_SYNC_CTRL_STATUS_EN
        chk("lost_sticky", lost, 1);
`endif
        l = 1; q = 0;
        repeat (3000) begin
            r = $urandom_range(499) == 0;
            if (l) l = $urandom_range(149) != 0;
            else   l = $urandom_range(9) == 0;
            if (ack || r) q = 0;
            else if (!q) q = $urandom_range(24) == 0;
            cycle(r, l, q);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
